// File: rtl/console_pkg.sv
// Shared definitions for the console text writer.
//   term_state_t : writer sequencer states
//   CH_*         : control codes the writer interprets, plus the blank fill byte
package console_pkg;

    typedef enum logic [1:0] {
        IDLE,
        NEWLINE,
        SCROLL_CLR,
        CLEAR_ALL
    } term_state_t;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;

endpackage

// File: rtl/term_clear_seq.sv
// Sweep counter used for both the one-row scroll clear and the full-screen clear.
//   clk, rst : clock, asynchronous active-high reset
//   start    : restart the sweep at offset 0
//   step     : advance one position this cycle
//   base     : start address of the sweep
//   last     : final offset (sweep length - 1)
//   addr     : (base + offset) mod 2^ADDR_W
//   done     : high on the stepped cycle that covers the final offset
module term_clear_seq #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] last,
    output logic [ADDR_W-1:0] addr,
    output logic              done
);

    logic [ADDR_W-1:0] sweep;

    // The offset folds back to 0 after the final position so the next sweep
    // starts clean even without an explicit start pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sweep <= '0;
        else if (start)
            sweep <= '0;
        else if (step)
            sweep <= (sweep == last) ? '0 : sweep + ADDR_W'(1);
    end

    always_comb begin
        addr = base + sweep;
        done = step && (sweep == last);
    end

endmodule

// File: rtl/text_term_writer.sv
// Character-stream to text-framebuffer writer.
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_data  : input byte stream, accepted when in_valid & in_ready
//   in_ready          : high while the writer is idle
//   vwr/vwaddr/vwdata : video RAM write port (registered)
//   vscroll           : circular display base offset for the read side
//   cursx, cursy      : cursor column / row
//   busy              : a clear or scroll sweep is in progress
module text_term_writer
    import console_pkg::*;
#(
    parameter int COLS     = 80,
    parameter int ROWS     = 25,
    parameter int ADDR_W   = 11,
    parameter int TAB_W    = 8,
    parameter int AUTOWRAP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              vwr,
    output logic [ADDR_W-1:0] vwaddr,
    output logic [7:0]        vwdata,
    output logic [ADDR_W-1:0] vscroll,
    output logic [6:0]        cursx,
    output logic [4:0]        cursy,
    output logic              busy
);

    localparam logic [6:0]        LAST_COL = 7'(COLS - 1);
    localparam logic [4:0]        LAST_ROW = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] SCREEN   = ADDR_W'(ROWS * COLS);

    term_state_t       state, state_nx;
    logic [6:0]        cursx_nx;
    logic [4:0]        cursy_nx;
    logic [ADDR_W-1:0] vscroll_nx;
    logic              vwr_nx;
    logic [ADDR_W-1:0] vwaddr_nx;
    logic [7:0]        vwdata_nx;
    logic [ADDR_W-1:0] cur_addr;
    logic [7:0]        tab_nx;
    logic              accept;

    logic              seq_start, seq_step, seq_done;
    logic [ADDR_W-1:0] seq_base, seq_last, seq_addr;

    term_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear (
        .clk   (clk),
        .rst   (rst),
        .start (seq_start),
        .step  (seq_step),
        .base  (seq_base),
        .last  (seq_last),
        .addr  (seq_addr),
        .done  (seq_done)
    );

    always_comb begin
        accept   = in_valid && in_ready;
        cur_addr = ADDR_W'(32'(cursy) * 32'(COLS) + 32'(cursx)) + vscroll;
        // Nine bits of headroom are not needed: COLS <= 127 keeps this in 8 bits.
        tab_nx   = {1'b0, cursx | 7'(TAB_W - 1)} + 8'd1;

        state_nx   = state;
        cursx_nx   = cursx;
        cursy_nx   = cursy;
        vscroll_nx = vscroll;
        vwr_nx     = 1'b0;
        vwaddr_nx  = vwaddr;
        vwdata_nx  = vwdata;
        seq_start  = 1'b0;
        seq_step   = 1'b0;
        seq_base   = '0;
        seq_last   = '1;

        case (state)
            IDLE: begin
                if (accept) begin
                    case (in_data)
                        CH_LF: begin
                            cursx_nx = '0;
                            state_nx = NEWLINE;
                        end
                        CH_CR: cursx_nx = '0;
                        CH_BS: begin
                            if (cursx != '0)
                                cursx_nx = cursx - 7'd1;
                        end
                        CH_TAB: cursx_nx = (tab_nx < {1'b0, LAST_COL}) ? tab_nx[6:0] : LAST_COL;
                        CH_FF: begin
                            cursx_nx   = '0;
                            cursy_nx   = '0;
                            vscroll_nx = '0;
                            seq_start  = 1'b1;
                            state_nx   = CLEAR_ALL;
                        end
                        default: begin
                            vwr_nx    = 1'b1;
                            vwaddr_nx = cur_addr;
                            vwdata_nx = in_data;
                            if (cursx < LAST_COL) begin
                                cursx_nx = cursx + 7'd1;
                            end else if (AUTOWRAP != 0) begin
                                cursx_nx = '0;
                                state_nx = NEWLINE;
                            end
                        end
                    endcase
                end
            end
            NEWLINE: begin
                if (cursy < LAST_ROW) begin
                    cursy_nx = cursy + 5'd1;
                    state_nx = IDLE;
                end else begin
                    seq_start = 1'b1;
                    state_nx  = SCROLL_CLR;
                end
            end
            SCROLL_CLR: begin
                // Blank the row just past the visible window; the base moves
                // only once the whole row is blank.
                seq_step  = 1'b1;
                seq_base  = vscroll + SCREEN;
                seq_last  = ADDR_W'(COLS - 1);
                vwr_nx    = 1'b1;
                vwaddr_nx = seq_addr;
                vwdata_nx = CH_SPACE;
                if (seq_done) begin
                    vscroll_nx = vscroll + COLS_A;
                    state_nx   = IDLE;
                end
            end
            CLEAR_ALL: begin
                seq_step  = 1'b1;
                vwr_nx    = 1'b1;
                vwaddr_nx = seq_addr;
                vwdata_nx = CH_SPACE;
                if (seq_done)
                    state_nx = IDLE;
            end
            default: state_nx = CLEAR_ALL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CLEAR_ALL;
            cursx    <= '0;
            cursy    <= '0;
            vscroll  <= '0;
            vwr      <= 1'b0;
            vwaddr   <= '0;
            vwdata   <= CH_SPACE;
            in_ready <= 1'b0;
            busy     <= 1'b1;
        end else begin
            state    <= state_nx;
            cursx    <= cursx_nx;
            cursy    <= cursy_nx;
            vscroll  <= vscroll_nx;
            vwr      <= vwr_nx;
            vwaddr   <= vwaddr_nx;
            vwdata   <= vwdata_nx;
            in_ready <= (state_nx == IDLE);
            busy     <= (state_nx == CLEAR_ALL) || (state_nx == SCROLL_CLR);
        end
    end

endmodule

// File: tb/tb_text_term_writer.sv
// Bench for text_term_writer: a default-geometry instance (80x25, autowrap)
// and a small instance (10x4, 64-word RAM, TAB_W=4, no autowrap).
module tb_text_term_writer;

    logic clk;
    logic rst;

    logic        in_valid0, in_ready0, vwr0, busy0;
    logic [7:0]  in_data0, vwdata0;
    logic [10:0] vwaddr0, vscroll0;
    logic [6:0]  cursx0;
    logic [4:0]  cursy0;

    logic        in_valid1, in_ready1, vwr1, busy1;
    logic [7:0]  in_data1, vwdata1;
    logic [5:0]  vwaddr1, vscroll1;
    logic [6:0]  cursx1;
    logic [4:0]  cursy1;

    text_term_writer #(
        .COLS(80), .ROWS(25), .ADDR_W(11), .TAB_W(8), .AUTOWRAP(1)
    ) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_data(in_data0),
        .in_ready(in_ready0), .vwr(vwr0), .vwaddr(vwaddr0), .vwdata(vwdata0),
        .vscroll(vscroll0), .cursx(cursx0), .cursy(cursy0), .busy(busy0)
    );

    text_term_writer #(
        .COLS(10), .ROWS(4), .ADDR_W(6), .TAB_W(4), .AUTOWRAP(0)
    ) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1),
        .in_ready(in_ready1), .vwr(vwr1), .vwaddr(vwaddr1), .vwdata(vwdata1),
        .vscroll(vscroll1), .cursx(cursx1), .cursy(cursy1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;
        int d;
    } wr_t;

    wr_t q0[$];
    wr_t q1[$];
    int  mcx[2], mcy[2], mvs[2];
    int  last_a[2], last_d[2];
    int  n_assert = 0;
    int  n_fail   = 0;

    function automatic int g_cols(input int d);  return (d == 0) ? 80 : 10; endfunction
    function automatic int g_rows(input int d);  return (d == 0) ? 25 : 4;  endfunction
    function automatic int g_mem(input int d);   return (d == 0) ? 2048 : 64; endfunction
    function automatic int g_tab(input int d);   return (d == 0) ? 8 : 4;   endfunction
    function automatic bit g_wrap(input int d);  return (d == 0);           endfunction

    function automatic logic [31:0] g_cx(input int d);  return (d == 0) ? 32'(cursx0) : 32'(cursx1); endfunction
    function automatic logic [31:0] g_cy(input int d);  return (d == 0) ? 32'(cursy0) : 32'(cursy1); endfunction
    function automatic logic [31:0] g_vs(input int d);  return (d == 0) ? 32'(vscroll0) : 32'(vscroll1); endfunction
    function automatic logic g_rdy(input int d);        return (d == 0) ? in_ready0 : in_ready1; endfunction

    task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, d, got, got, exp, exp, $time);
        end
    endtask

    task automatic push(input int d, input int a, input int dt);
        wr_t e;
        e.a = a;
        e.d = dt;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    // Model: what a full clear / a byte must do to the screen, cursor and base.
    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mcx[d] = 0; mcy[d] = 0; mvs[d] = 0;
            if (d == 0) q0.delete(); else q1.delete();
            for (int k = 0; k < g_mem(d); k++) push(d, k, 8'h20);
        end
    endtask

    task automatic model_newline(input int d);
        int c, r, m;
        c = g_cols(d); r = g_rows(d); m = g_mem(d);
        if (mcy[d] < r - 1) begin
            mcy[d]++;
        end else begin
            for (int k = 0; k < c; k++) push(d, (mvs[d] + r * c + k) % m, 8'h20);
            mvs[d] = (mvs[d] + c) % m;
        end
    endtask

    task automatic model_byte(input int d, input logic [7:0] b);
        int c, m, t;
        c = g_cols(d); m = g_mem(d);
        case (b)
            8'h0A: begin mcx[d] = 0; model_newline(d); end
            8'h0D: mcx[d] = 0;
            8'h08: if (mcx[d] > 0) mcx[d]--;
            8'h09: begin
                t = (mcx[d] | (g_tab(d) - 1)) + 1;
                mcx[d] = (t < c - 1) ? t : c - 1;
            end
            8'h0C: begin
                mcx[d] = 0; mcy[d] = 0; mvs[d] = 0;
                for (int k = 0; k < m; k++) push(d, k, 8'h20);
            end
            default: begin
                push(d, (mcy[d] * c + mcx[d] + mvs[d]) % m, int'(b));
                if (mcx[d] < c - 1) mcx[d]++;
                else if (g_wrap(d)) begin mcx[d] = 0; model_newline(d); end
            end
        endcase
    endtask

    task automatic cmp_port(input int d, input logic wr, input logic [10:0] a,
                            input logic [7:0] dt, input logic rdy, input logic bsy);
        wr_t e;
        chk("ready_while_busy", d, 32'(rdy & bsy), 32'd0);
        if (wr) begin
            if (qsize(d) == 0) begin
                chk("unexpected_write_addr", d, 32'(a), 32'hFFFF_FFFF);
            end else begin
                if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
                chk("wr_addr", d, 32'(a), 32'(e.a));
                chk("wr_data", d, 32'(dt), 32'(e.d));
            end
            last_a[d] = int'(a);
            last_d[d] = int'(dt);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            cmp_port(0, vwr0, vwaddr0, vwdata0, in_ready0, busy0);
            cmp_port(1, vwr1, {5'b0, vwaddr1}, vwdata1, in_ready1, busy1);
        end
    end

    task automatic set_in(input int d, input logic v, input logic [7:0] b);
        if (d == 0) begin in_valid0 = v; in_data0 = b; end
        else        begin in_valid1 = v; in_data1 = b; end
    endtask

    task automatic send(input int d, input logic [7:0] b);
        int n;
        @(negedge clk);
        set_in(d, 1'b1, b);
        n = 0;
        while (!g_rdy(d) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!g_rdy(d)) begin
            n_assert++;
            n_fail++;
            $display("FAIL send_timeout dut%0d: in_ready still 0 after %0d cycles, required 1", d, n);
            set_in(d, 1'b0, 8'h00);
        end else begin
            model_byte(d, b);
            @(posedge clk);
            #1 set_in(d, 1'b0, 8'h00);
        end
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        @(negedge clk);
        while (!g_rdy(d) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", d, 32'(g_rdy(d)), 32'd1);
        @(negedge clk);
        #1;
    endtask

    task automatic check_state(input int d);
        chk("cursx", d, g_cx(d), 32'(mcx[d]));
        chk("cursy", d, g_cy(d), 32'(mcy[d]));
        chk("vscroll", d, g_vs(d), 32'(mvs[d]));
        chk("writes_drained", d, 32'(qsize(d)), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 1'b0, 8'h00);
        set_in(1, 1'b0, 8'h00);
        last_a = '{0, 0};
        last_d = '{0, 0};
        model_reset();

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_vwr", 0, 32'(vwr0), 32'd0);
        chk("rst_vwaddr", 0, 32'(vwaddr0), 32'd0);
        chk("rst_vwdata", 0, 32'(vwdata0), 32'h20);
        chk("rst_vscroll", 0, 32'(vscroll0), 32'd0);
        chk("rst_cursor", 0, {cursx0, cursy0}, 32'd0);
        chk("rst_in_ready", 0, 32'(in_ready0), 32'd0);
        chk("rst_busy", 0, 32'(busy0), 32'd1);
        chk("rst_busy", 1, 32'(busy1), 32'd1);
        chk("rst_in_ready", 1, 32'(in_ready1), 32'd0);
        chk("rst_vwdata", 1, 32'(vwdata1), 32'h20);
        #1 rst = 1'b0;

        // 1: power-on clear of the whole RAM
        wait_idle(0);
        wait_idle(1);
        check_state(0);
        check_state(1);
        chk("clear_last_addr", 0, 32'(last_a[0]), 32'd2047);
        chk("clear_last_addr", 1, 32'(last_a[1]), 32'd63);
        chk("idle_busy", 0, 32'(busy0), 32'd0);

        // 2: printables and CR
        send(0, "A"); send(0, "B"); send(0, 8'h0D); send(0, "C");
        wait_idle(0);
        check_state(0);
        chk("t2_cursx", 0, 32'(cursx0), 32'd1);
        chk("t2_last_addr", 0, 32'(last_a[0]), 32'd0);
        chk("t2_last_data", 0, 32'(last_d[0]), 32'h43);

        // 3: LFs saturate at the bottom row, then scroll twice
        repeat (26) send(0, 8'h0A);
        wait_idle(0);
        check_state(0);
        chk("t3_cursy", 0, 32'(cursy0), 32'd24);
        chk("t3_vscroll", 0, 32'(vscroll0), 32'd160);

        // 4: scroll base wraps around the RAM
        repeat (22) send(0, 8'h0A);
        wait_idle(0);
        chk("t4_vscroll_pre", 0, 32'(vscroll0), 32'd1920);
        send(0, 8'h0A);
        wait_idle(0);
        chk("t4_vscroll", 0, 32'(vscroll0), 32'd2000);
        chk("t4_clear_last", 0, 32'(last_a[0]), 32'd1951);
        send(0, "P");
        wait_idle(0);
        check_state(0);
        chk("t4_print_addr", 0, 32'(last_a[0]), 32'd1872);

        // 5a: FF, tab to the last column, autowrap
        send(0, 8'h0C);
        wait_idle(0);
        check_state(0);
        repeat (9) send(0, 8'h09);
        repeat (5) send(0, "a");
        wait_idle(0);
        chk("t5_cursx77", 0, 32'(cursx0), 32'd77);
        send(0, 8'h09);
        wait_idle(0);
        chk("t5_tab_clamp", 0, 32'(cursx0), 32'd79);
        send(0, "X");
        wait_idle(0);
        check_state(0);
        chk("t5_wrap_x", 0, 32'(cursx0), 32'd0);
        chk("t5_wrap_y", 0, 32'(cursy0), 32'd1);
        chk("t5_x_addr", 0, 32'(last_a[0]), 32'd79);

        // 5b: no autowrap, overwrite at the last column, backspace
        send(1, 8'h09); send(1, "a"); send(1, "b"); send(1, "c");
        send(1, 8'h09); send(1, 8'h09);
        wait_idle(1);
        chk("t5b_cursx9", 1, 32'(cursx1), 32'd9);
        send(1, "X");
        wait_idle(1);
        chk("t5b_x_addr", 1, 32'(last_a[1]), 32'd9);
        chk("t5b_stick", 1, 32'(cursx1), 32'd9);
        send(1, "Y");
        wait_idle(1);
        check_state(1);
        chk("t5b_y_addr", 1, 32'(last_a[1]), 32'd9);
        chk("t5b_y_data", 1, 32'(last_d[1]), 32'h59);
        send(1, 8'h08);
        wait_idle(1);
        chk("t5b_bs", 1, 32'(cursx1), 32'd8);
        send(1, 8'h0D); send(1, 8'h08);
        wait_idle(1);
        check_state(1);
        chk("t5b_bs_at_0", 1, 32'(cursx1), 32'd0);

        // 6a: byte held across a scroll
        repeat (4) send(1, 8'h0A);
        send(1, "Z");
        wait_idle(1);
        check_state(1);
        chk("t6_vscroll", 1, 32'(vscroll1), 32'd10);
        chk("t6_z_addr", 1, 32'(last_a[1]), 32'd40);

        // 6b: reset in the middle of a full clear, with a byte held pending
        send(1, 8'h0C);
        fork
            send(1, "Q");
            begin
                repeat (20) @(negedge clk);
                #2 rst = 1'b1;
                model_reset();
                @(negedge clk);
                #2 rst = 1'b0;
            end
        join
        wait_idle(1);
        wait_idle(0);
        check_state(0);
        check_state(1);
        chk("t6_vscroll_rst", 1, 32'(vscroll1), 32'd0);
        chk("t6_q_addr", 1, 32'(last_a[1]), 32'd0);
        chk("t6_q_data", 1, 32'(last_d[1]), 32'h51);
        chk("t6_cursx", 1, 32'(cursx1), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
